renkon_ctrl_pool: RTL and testbench

Control stage for 2x2, stride-2 max pooling, directly downstream of the ReLU control stage on the renkon ctrl_bus chain. Tracks raster position of each valid pixel, drives the line buffer and compare enables of the pooling datapath, and re-times start/valid/stop so out_ctrl.valid fires once per completed window. With pooling disabled it is a 1-cycle control register.

---
 rtl/renkon_ctrl_pool_pkg.sv | 21 ++
 rtl/ctrl_bus.sv | 14 +
 rtl/renkon_pool_pos.sv | 49 ++++
 rtl/renkon_ctrl_pool.sv | 123 ++++++++++++
 tb/tb_renkon_ctrl_pool.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/renkon_ctrl_pool_pkg.sv
// Shared constants and types for the renkon control chain: stage latencies,
// ctrl_bus field widths and the pooling FSM state encoding.
package renkon_ctrl_pool_pkg;

    localparam int D_RELU  = 1;
    localparam int D_POOL  = 3;
    localparam int DELAYW  = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_FLUSH  = 2'd2
    } pool_state_e;

    typedef struct packed {
        logic start;
        logic valid;
        logic stop;
    } ctrl_reg_t;

endpackage

// File: rtl/ctrl_bus.sv
// Control bus between renkon stages. Upstream raises start once per frame,
// valid once per pixel and stop with or after the last pixel; ready flows back.
interface ctrl_bus;
    import renkon_ctrl_pool_pkg::*;

    logic              start;
    logic              valid;
    logic              stop;
    logic              ready;
    logic [DELAYW-1:0] delay;

    modport master (output start, output valid, output stop, output delay, input ready);
    modport slave  (input start, input valid, input stop, input delay, output ready);
endinterface

// File: rtl/renkon_pool_pos.sv
// Raster position of counted pixels and the decode of each position into
// its role in a 2x2 stride-2 window.
module renkon_pool_pos #(
    parameter int SIZEW = 6
) (
    input  logic             clk,
    input  logic             xrst,
    input  logic             clr,
    input  logic             adv,
    input  logic [SIZEW-1:0] fea_size,
    output logic             is_hld,
    output logic             is_hmax,
    output logic             is_we,
    output logic             is_re,
    output logic [SIZEW-2:0] pair_idx
);
    logic [SIZEW-1:0] col;
    logic [SIZEW-1:0] row;
    logic [SIZEW-1:0] last;
    logic             col_wrap;
    logic             row_wrap;
    logic             row_ok;

    assign last     = fea_size - SIZEW'(1);
    assign col_wrap = (col == last);
    assign row_wrap = (row == last);

    always_ff @(posedge clk) begin
        if (xrst || clr) begin
            col <= '0;
            row <= '0;
        end else if (adv) begin
            if (col_wrap) begin
                col <= '0;
                row <= row_wrap ? '0 : row + SIZEW'(1);
            end else begin
                col <= col + SIZEW'(1);
            end
        end
    end

    // The unpaired last row of an odd-sized map never belongs to a window.
    assign row_ok   = !(fea_size[0] && row_wrap);
    assign is_hld   = ~col[0] & row_ok;
    assign is_hmax  =  col[0] & row_ok;
    assign is_we    =  col[0] & ~row[0] & row_ok;
    assign is_re    =  col[0] &  row[0] & row_ok;
    assign pair_idx = col[SIZEW-1:1];
endmodule

// File: rtl/renkon_ctrl_pool.sv
// Control stage for 2x2 stride-2 max pooling: sequences the pooling datapath
// and re-times start/valid/stop so valid fires once per completed window.
module renkon_ctrl_pool
    import renkon_ctrl_pool_pkg::*;
#(
    parameter int MAXSIZE = 32,
    parameter int SIZEW   = $clog2(MAXSIZE + 1)
) (
    input  logic             clk,
    input  logic             xrst,
    input  logic             _pool_en,
    input  logic [SIZEW-1:0] _fea_size,
    ctrl_bus.slave           in_ctrl,
    ctrl_bus.master          out_ctrl,
    output logic             pool_hld,
    output logic             pool_hmax,
    output logic             buf_we,
    output logic             buf_re,
    output logic [SIZEW-2:0] buf_addr,
    output logic             pool_oe,
    output pool_state_e      dbg_state
);
    localparam logic [DELAYW-1:0] DELAY_POOL = DELAYW'(D_POOL);
    localparam logic [DELAYW-1:0] DELAY_BYP  = DELAYW'(1);

    pool_state_e      state, state_nx;
    logic [1:0]       flush_cnt, flush_cnt_nx;
    logic [D_POOL-1:0] start_sr, stop_sr;
    logic             byp_valid_q;
    logic             win_valid_q;
    logic             counted, clr;
    logic             is_hld, is_hmax, is_we, is_re;
    logic [SIZEW-2:0] pair_idx;
    ctrl_reg_t        out_c;

    // A valid sharing its cycle with start belongs to no frame position.
    assign counted = _pool_en & in_ctrl.valid & (state == ST_ACTIVE) & ~in_ctrl.start;
    assign clr     = _pool_en & in_ctrl.start;

    renkon_pool_pos #(.SIZEW(SIZEW)) u_pos (
        .clk      (clk),
        .xrst     (xrst),
        .clr      (clr),
        .adv      (counted),
        .fea_size (_fea_size),
        .is_hld   (is_hld),
        .is_hmax  (is_hmax),
        .is_we    (is_we),
        .is_re    (is_re),
        .pair_idx (pair_idx)
    );

    assign pool_hld  = counted & is_hld;
    assign pool_hmax = counted & is_hmax;

    always_comb begin
        state_nx     = state;
        flush_cnt_nx = flush_cnt;
        if (!_pool_en) begin
            state_nx = ST_IDLE;
        end else if (in_ctrl.start) begin
            state_nx = ST_ACTIVE;
        end else begin
            case (state)
                ST_ACTIVE: if (in_ctrl.stop) begin
                    state_nx     = ST_FLUSH;
                    flush_cnt_nx = '0;
                end
                ST_FLUSH: begin
                    if (flush_cnt == 2'(D_POOL - 1)) state_nx = ST_IDLE;
                    else                             flush_cnt_nx = flush_cnt + 2'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (xrst) begin
            state       <= ST_IDLE;
            flush_cnt   <= '0;
            buf_we      <= 1'b0;
            buf_re      <= 1'b0;
            buf_addr    <= '0;
            pool_oe     <= 1'b0;
            win_valid_q <= 1'b0;
            byp_valid_q <= 1'b0;
            start_sr    <= '0;
            stop_sr     <= '0;
        end else begin
            state       <= state_nx;
            flush_cnt   <= flush_cnt_nx;
            buf_we      <= counted & is_we;
            buf_re      <= counted & is_re;
            if (counted && (is_we || is_re)) buf_addr <= pair_idx;
            pool_oe     <= buf_re;
            win_valid_q <= pool_oe;
            byp_valid_q <= in_ctrl.valid;
            start_sr    <= {start_sr[D_POOL-2:0], in_ctrl.start};
            stop_sr     <= {stop_sr[D_POOL-2:0], in_ctrl.stop};
        end
    end

    always_comb begin
        out_c = '0;
        if (_pool_en) begin
            out_c.start = start_sr[D_POOL-1];
            out_c.valid = win_valid_q;
            out_c.stop  = stop_sr[D_POOL-1];
        end else begin
            out_c.start = start_sr[0];
            out_c.valid = byp_valid_q;
            out_c.stop  = stop_sr[0];
        end
    end

    assign out_ctrl.start = out_c.start;
    assign out_ctrl.valid = out_c.valid;
    assign out_ctrl.stop  = out_c.stop;
    assign out_ctrl.delay = in_ctrl.delay + (_pool_en ? DELAY_POOL : DELAY_BYP);
    assign in_ctrl.ready  = out_ctrl.ready;
    assign dbg_state      = state;
endmodule

// File: tb/tb_renkon_ctrl_pool.sv
// Scoreboard bench for renkon_ctrl_pool: a pixel-index model predicts every
// output event by cycle; a negedge monitor matches DUT events against it.
module tb_renkon_ctrl_pool;
  import renkon_ctrl_pool_pkg::*;

  localparam int MAXSIZE = 32;
  localparam int SIZEW   = $clog2(MAXSIZE + 1);
  localparam int W       = 40;
  localparam int K_HLD = 0, K_HMAX = 1, K_WE = 2, K_RE = 3, K_OE = 4, K_VALID = 5, K_START = 6, K_STOP = 7;

  logic clk = 1'b0;
  logic xrst;
  logic pool_en;
  logic [SIZEW-1:0] fea_size;
  logic pool_hld, pool_hmax, buf_we, buf_re, pool_oe;
  logic [SIZEW-2:0] buf_addr;
  pool_state_e dbg_state;

  ctrl_bus in_if ();
  ctrl_bus out_if ();

  renkon_ctrl_pool #(.MAXSIZE(MAXSIZE)) dut (
    .clk       (clk),
    .xrst      (xrst),
    ._pool_en  (pool_en),
    ._fea_size (fea_size),
    .in_ctrl   (in_if),
    .out_ctrl  (out_if),
    .pool_hld  (pool_hld),
    .pool_hmax (pool_hmax),
    .buf_we    (buf_we),
    .buf_re    (buf_re),
    .buf_addr  (buf_addr),
    .pool_oe   (pool_oe),
    .dbg_state (dbg_state)
  );

  // clock / cycle index
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard: {kind, cycle, addr}
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  // reference model state: frame open flag and linear pixel index
  bit m_active = 1'b0;
  int m_pix = 0;
  int m_size = 4;

  function automatic string kname(input int k);
    case (k)
      K_HLD:   return "pool_hld";
      K_HMAX:  return "pool_hmax";
      K_WE:    return "buf_we";
      K_RE:    return "buf_re";
      K_OE:    return "pool_oe";
      K_VALID: return "out_valid";
      K_START: return "out_start";
      default: return "out_stop";
    endcase
  endfunction

  task automatic push(input int k, input int c, input int a);
    exp_q.push_back({8'(k), 24'(c), 8'(a)});
  endtask

  task automatic model(input bit s, input bit v, input bit p);
    int t, r, c;
    t = cyc;
    if (!pool_en) begin
      if (s) push(K_START, t + 1, 0);
      if (v) push(K_VALID, t + 1, 0);
      if (p) push(K_STOP, t + 1, 0);
    end else begin
      if (s) push(K_START, t + D_POOL, 0);
      if (p) push(K_STOP, t + D_POOL, 0);
      if (s) begin
        m_active = 1'b1;
        m_pix = 0;
      end else if (m_active) begin
        if (v) begin
          r = m_pix / m_size;
          c = m_pix % m_size;
          if (!((m_size % 2 == 1) && (r == m_size - 1))) begin
            if (c % 2 == 0) push(K_HLD, t, 0);
            else begin
              push(K_HMAX, t, 0);
              if (r % 2 == 0) push(K_WE, t + 1, c / 2);
              else begin
                push(K_RE, t + 1, c / 2);
                push(K_OE, t + 2, 0);
                push(K_VALID, t + D_POOL, 0);
              end
            end
          end
          m_pix = (m_pix + 1) % (m_size * m_size);
        end
        if (p) m_active = 1'b0;
      end
    end
  endtask

  // driver tasks
  task automatic drive(input bit s, input bit v, input bit p);
    in_if.start = s;
    in_if.valid = v;
    in_if.stop  = p;
    in_if.delay = 8'($urandom_range(0, 200));
    out_if.ready = 1'($urandom_range(0, 1));
    model(s, v, p);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    xrst = 1'b1;
    for (int i = exp_q.size() - 1; i >= 0; i--)
      if (exp_q[i][31:8] > 24'(cyc)) exp_q.delete(i);
    m_active = 1'b0;
    idle(2);
    xrst = 1'b0;
  endtask

  task automatic frame(input int size, input int npix, input int gap, input bit rnd_gap,
                       input int abort_at, input int restart_at);
    int g;
    fea_size = SIZEW'(size);
    m_size = size;
    drive(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < npix; i++) begin
      if (i == abort_at) begin
        do_reset();
        idle(4);
        return;
      end
      if (i == restart_at) drive(1'b1, 1'b0, 1'b0);
      g = rnd_gap ? $urandom_range(0, gap) : gap;
      idle(g);
      drive(1'b0, 1'b1, i == npix - 1);
    end
    idle(6);
  endtask

  // monitor: pops expected events as the DUT presents them
  always @(negedge clk) begin
    logic [7:0] act;
    logic [DELAYW-1:0] exp_delay;
    int hit;
    if (mon_en) begin
      act = {out_if.stop, out_if.start, out_if.valid, pool_oe, buf_re, buf_we, pool_hmax, pool_hld};
      for (int k = 0; k < 8; k++) begin
        hit = -1;
        for (int i = 0; i < exp_q.size(); i++)
          if (exp_q[i][39:32] == 8'(k) && exp_q[i][31:8] == 24'(cyc)) hit = i;
        if (act[k] || hit >= 0) begin
          checks++;
          if (!act[k]) begin
            errors++;
            $display("FAIL %s cycle %0d: got 0 want 1", kname(k), cyc);
            exp_q.delete(hit);
          end else if (hit < 0) begin
            errors++;
            $display("FAIL %s cycle %0d: got 1 want 0", kname(k), cyc);
          end else begin
            if ((k == K_WE || k == K_RE) && buf_addr != exp_q[hit][SIZEW-2:0]) begin
              errors++;
              $display("FAIL buf_addr cycle %0d: got %0d want %0d", cyc, buf_addr, exp_q[hit][7:0]);
            end
            exp_q.delete(hit);
          end
        end
      end
      checks++;
      if (in_if.ready !== out_if.ready) begin
        errors++;
        $display("FAIL ready cycle %0d: got %b want %b", cyc, in_if.ready, out_if.ready);
      end
      exp_delay = in_if.delay + (pool_en ? 8'(D_POOL) : 8'd1);
      checks++;
      if (out_if.delay !== exp_delay) begin
        errors++;
        $display("FAIL delay cycle %0d: got %0d want %0d", cyc, out_if.delay, exp_delay);
      end
      checks++;
      if (buf_we && buf_re) begin
        errors++;
        $display("FAIL we_re_excl cycle %0d: got both want at most one", cyc);
      end
    end
  end

  initial begin
    xrst = 1'b1;
    pool_en = 1'b1;
    fea_size = SIZEW'(4);
    in_if.start = 1'b0;
    in_if.valid = 1'b0;
    in_if.stop = 1'b0;
    in_if.delay = '0;
    out_if.ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({out_if.start, out_if.valid, out_if.stop, buf_we, buf_re, pool_oe, pool_hld, pool_hmax} !== 8'd0
        || buf_addr !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got nonzero want all 0");
    end
    checks++;
    if (dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_IDLE);
    end
    @(posedge clk);
    #1;
    xrst = 1'b0;
    mon_en = 1'b1;
    idle(2);

    frame(4, 16, 0, 1'b0, -1, -1);    // single 4x4 frame back-to-back
    frame(5, 25, 0, 1'b0, -1, -1);    // odd edge
    pool_en = 1'b0;
    idle(4);
    frame(4, 8, 0, 1'b0, -1, -1);     // bypass mode
    frame(3, 6, 1, 1'b1, -1, -1);
    pool_en = 1'b1;
    idle(4);
    frame(4, 32, 2, 1'b0, -1, -1);    // two channels, fixed gaps
    frame(4, 16, 0, 1'b0, 6, -1);     // reset mid-frame
    frame(4, 16, 0, 1'b0, -1, -1);
    frame(4, 16, 0, 1'b0, -1, 7);     // restart mid-frame
    frame(2, 4, 0, 1'b0, -1, -1);
    for (int n = 0; n < 6; n++) begin
      int sz;
      sz = $urandom_range(2, 8);
      frame(sz, $urandom_range(1, 2 * sz * sz), 2, 1'b1, -1, -1);
    end
    idle(8);

    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      errors++;
      $display("FAIL %s cycle %0d: got none want pending", kname(int'(exp_q[i][39:32])), exp_q[i][31:8]);
    end
    checks++;
    if (dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL final_state: got %0d want %0d", dbg_state, ST_IDLE);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
